// File: rtl/axil_flood_responder_if.sv
// AXI4-Lite bus bundle between a master and the axil_flood_responder slave.
interface axil_flood_responder_if;
  logic [11:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [11:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axil_flood_responder.sv
// AXI4-Lite register slave with independent AW/W holding registers, a queued
// write-response FIFO that back-pressures AW/W when full, and an AW stall counter.
module axil_flood_responder #(
  parameter int DEPTH = 4,
  parameter int NREGS = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  axil_flood_responder_if.slave bus,
  output logic [15:0]           stall_count,
  output logic [4:0]            fifo_level
);
  localparam int              IW          = $clog2(NREGS);
  localparam int              PW          = $clog2(DEPTH);
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;
  localparam logic [4:0]      DEPTH_L     = 5'(DEPTH);
  localparam logic [PW-1:0]   PTR_LAST    = PW'(DEPTH - 1);
  // Any set bit above the index field, or in the byte offset, is out of range.
  localparam logic [11:0]     OOR_MASK    = ~12'(NREGS * 4 - 1) | 12'h003;

  function automatic logic in_range(input logic [11:0] addr);
    return (addr & OOR_MASK) == 12'h000;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
      else         res[8*i +: 8] = old_v[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  logic          aw_held_q, aw_held_d;
  logic [11:0]   aw_addr_q, aw_addr_d;
  logic          w_held_q, w_held_d;
  logic [31:0]   w_data_q, w_data_d;
  logic [3:0]    w_strb_q, w_strb_d;
  logic [1:0]    resp_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [4:0]    level_q, level_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [15:0]   stall_q, stall_d;
  logic [31:0]   regs_q [NREGS];

  logic          aw_ready_s, w_ready_s, ar_ready_s;
  logic          aw_hs_s, w_hs_s, ar_hs_s, pop_s, commit_s, commit_ok_s;
  logic [IW-1:0] aw_idx_s, ar_idx_s;

  assign aw_ready_s  = !reset_n && !aw_held_q;
  assign w_ready_s   = !reset_n && !w_held_q;
  assign ar_ready_s  = !reset_n && !rvalid_q;
  assign aw_hs_s     = bus.s_awvalid && aw_ready_s;
  assign w_hs_s      = bus.s_wvalid && w_ready_s;
  assign ar_hs_s     = bus.s_arvalid && ar_ready_s;
  assign pop_s       = (level_q != 5'd0) && bus.s_bready;
  assign commit_s    = aw_held_q && w_held_q && ((level_q < DEPTH_L) || pop_s);
  assign commit_ok_s = in_range(aw_addr_q);
  assign aw_idx_s    = aw_addr_q[IW+1:2];
  assign ar_idx_s    = bus.s_araddr[IW+1:2];

  assign bus.s_awready = aw_ready_s;
  assign bus.s_wready  = w_ready_s;
  assign bus.s_arready = ar_ready_s;
  assign bus.s_bvalid  = (level_q != 5'd0);
  assign bus.s_bresp   = resp_q[rd_ptr_q];
  assign bus.s_rvalid  = rvalid_q;
  assign bus.s_rdata   = rdata_q;
  assign bus.s_rresp   = rresp_q;
  assign stall_count   = stall_q;
  assign fifo_level    = level_q;

  // Next-state for holds, FIFO pointers/level, read channel and stall counter.
  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    level_d   = level_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    stall_d   = stall_q;

    // A hold cannot fill in its commit cycle because its ready is low then.
    if (commit_s) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end else begin
      if (aw_hs_s) begin
        aw_held_d = 1'b1;
        aw_addr_d = bus.s_awaddr;
      end else begin
        aw_held_d = aw_held_q;
      end
      if (w_hs_s) begin
        w_held_d = 1'b1;
        w_data_d = bus.s_wdata;
        w_strb_d = bus.s_wstrb;
      end else begin
        w_held_d = w_held_q;
      end
    end

    if (commit_s) wr_ptr_d = ptr_next(wr_ptr_q);
    else          wr_ptr_d = wr_ptr_q;
    if (pop_s)    rd_ptr_d = ptr_next(rd_ptr_q);
    else          rd_ptr_d = rd_ptr_q;

    case ({commit_s, pop_s})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase

    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      if (in_range(bus.s_araddr)) begin
        rdata_d = regs_q[ar_idx_s];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = 32'd0;
        rresp_d = RESP_SLVERR;
      end
    end else if (rvalid_q && bus.s_rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end

    if (bus.s_awvalid && !aw_ready_s && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    else                                                       stall_d = stall_q;
  end

  // State registers, response FIFO storage and register file.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= 12'd0;
      w_held_q  <= 1'b0;
      w_data_q  <= 32'd0;
      w_strb_q  <= 4'd0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level_q   <= 5'd0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
      stall_q   <= 16'd0;
      for (int i = 0; i < DEPTH; i++) resp_q[i] <= 2'b00;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 32'd0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      stall_q   <= stall_d;
      if (commit_s) begin
        resp_q[wr_ptr_q] <= commit_ok_s ? RESP_OKAY : RESP_SLVERR;
        if (commit_ok_s) regs_q[aw_idx_s] <= merge_bytes(regs_q[aw_idx_s], w_data_q, w_strb_q);
      end
    end
  end
endmodule

// File: tb/tb_axil_flood_responder.sv
// Directed bench for axil_flood_responder: a table of single write/read
// transactions plus hand sequences for ordering, backpressure and reset.
module tb_axil_flood_responder;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] stall_count;
  logic [4:0]  fifo_level;
  int          checks = 0;
  int          errors = 0;

  axil_flood_responder_if bus();

  axil_flood_responder #(.DEPTH(4), .NREGS(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .stall_count (stall_count),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic clear_inputs();
    bus.s_awaddr  = 12'd0;
    bus.s_awvalid = 1'b0;
    bus.s_wdata   = 32'd0;
    bus.s_wstrb   = 4'd0;
    bus.s_wvalid  = 1'b0;
    bus.s_bready  = 1'b1;
    bus.s_araddr  = 12'd0;
    bus.s_arvalid = 1'b0;
    bus.s_rready  = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b1;
    clear_inputs();
    #1;
    check("rst_awready", bus.s_awready, 1'b0);
    check("rst_wready", bus.s_wready, 1'b0);
    check("rst_arready", bus.s_arready, 1'b0);
    check("rst_bvalid", bus.s_bvalid, 1'b0);
    check("rst_rvalid", bus.s_rvalid, 1'b0);
    check("rst_rdata", bus.s_rdata, 32'd0);
    check("rst_bresp", bus.s_bresp, 2'b00);
    check("rst_rresp", bus.s_rresp, 2'b00);
    check("rst_level", fifo_level, 5'd0);
    check("rst_stall", stall_count, 16'd0);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("rel_awready", bus.s_awready, 1'b1);
    check("rel_wready", bus.s_wready, 1'b1);
    check("rel_arready", bus.s_arready, 1'b1);
  endtask

  task automatic write_chk(input string name, input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
    bus.s_awaddr  = addr;
    bus.s_wdata   = data;
    bus.s_wstrb   = strb;
    bus.s_awvalid = 1'b1;
    bus.s_wvalid  = 1'b1;
    bus.s_bready  = 1'b1;
    check({name, "_awready"}, bus.s_awready, 1'b1);
    tick();
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    check({name, "_b_early"}, bus.s_bvalid, 1'b0);
    tick();
    check({name, "_bvalid"}, bus.s_bvalid, 1'b1);
    check({name, "_bresp"}, bus.s_bresp, exp_resp);
    tick();
    check({name, "_b_popped"}, bus.s_bvalid, 1'b0);
  endtask

  task automatic read_chk(input string name, input logic [11:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    bus.s_araddr  = addr;
    bus.s_arvalid = 1'b1;
    bus.s_rready  = 1'b0;
    check({name, "_arready"}, bus.s_arready, 1'b1);
    tick();
    bus.s_arvalid = 1'b0;
    check({name, "_rvalid"}, bus.s_rvalid, 1'b1);
    check({name, "_rdata"}, bus.s_rdata, exp_data);
    check({name, "_rresp"}, bus.s_rresp, exp_resp);
    check({name, "_ar_blocked"}, bus.s_arready, 1'b0);
    tick();
    check({name, "_rdata_hold"}, bus.s_rdata, exp_data);
    bus.s_rready = 1'b1;
    tick();
    bus.s_rready = 1'b0;
    check({name, "_r_done"}, bus.s_rvalid, 1'b0);
  endtask

  initial begin
    int nresp;
    vecs[0] = '{1'b1, 12'h004, 32'hCAFE0001, 4'hF, OKAY,   32'hCAFE0001, OKAY};
    vecs[1] = '{1'b1, 12'h008, 32'h12345678, 4'hF, OKAY,   32'h12345678, OKAY};
    vecs[2] = '{1'b1, 12'h008, 32'hFFFFFFFF, 4'h3, OKAY,   32'h1234FFFF, OKAY};
    vecs[3] = '{1'b1, 12'h100, 32'hDEADBEEF, 4'hF, SLVERR, 32'h00000000, SLVERR};
    vecs[4] = '{1'b1, 12'h00A, 32'h5555AAAA, 4'hF, SLVERR, 32'h00000000, SLVERR};
    vecs[5] = '{1'b1, 12'h03C, 32'hA5A5A5A5, 4'h9, OKAY,   32'hA50000A5, OKAY};
    vecs[6] = '{1'b1, 12'h040, 32'h11111111, 4'hF, SLVERR, 32'h00000000, SLVERR};
    vecs[7] = '{1'b0, 12'h004, 32'h00000000, 4'h0, OKAY,   32'hCAFE0001, OKAY};
    vecs[8] = '{1'b1, 12'h000, 32'hFFFFFFFF, 4'h0, OKAY,   32'h00000000, OKAY};
    vecs[9] = '{1'b0, 12'h008, 32'h00000000, 4'h0, OKAY,   32'h1234FFFF, OKAY};

    clear_inputs();
    #3;
    apply_reset();

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].do_wr)
        write_chk($sformatf("vec%0d_wr", v), vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, vecs[v].exp_bresp);
      read_chk($sformatf("vec%0d_rd", v), vecs[v].addr, vecs[v].exp_rdata, vecs[v].exp_rresp);
    end

    // Read and commit to the same register on the same edge sees the old value.
    write_chk("same_pre", 12'h010, 32'h11112222, 4'hF, OKAY);
    bus.s_awaddr = 12'h010; bus.s_wdata = 32'h33334444; bus.s_wstrb = 4'hF;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    bus.s_araddr = 12'h010; bus.s_arvalid = 1'b1; bus.s_rready = 1'b0;
    tick();
    bus.s_arvalid = 1'b0;
    check("same_rvalid", bus.s_rvalid, 1'b1);
    check("same_old_data", bus.s_rdata, 32'h11112222);
    check("same_bvalid", bus.s_bvalid, 1'b1);
    bus.s_rready = 1'b1;
    tick();
    bus.s_rready = 1'b0;
    read_chk("same_new", 12'h010, 32'h33334444, OKAY);

    // W three cycles ahead of AW: one commit, only after AW arrives.
    write_chk("wfirst_pre", 12'h008, 32'h12345678, 4'hF, OKAY);
    bus.s_wdata = 32'hFFFFFFFF; bus.s_wstrb = 4'h3; bus.s_wvalid = 1'b1;
    tick();
    bus.s_wvalid = 1'b0;
    check("wfirst_wready", bus.s_wready, 1'b0);
    check("wfirst_awready", bus.s_awready, 1'b1);
    tick();
    tick();
    check("wfirst_no_b", bus.s_bvalid, 1'b0);
    bus.s_awaddr = 12'h008; bus.s_awvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0;
    check("wfirst_b_early", bus.s_bvalid, 1'b0);
    tick();
    check("wfirst_bvalid", bus.s_bvalid, 1'b1);
    check("wfirst_level1", fifo_level, 5'd1);
    tick();
    check("wfirst_one_resp", bus.s_bvalid, 1'b0);
    check("wfirst_level0", fifo_level, 5'd0);
    read_chk("wfirst_rd", 12'h008, 32'h1234FFFF, OKAY);

    // Flood with bready low: four queued, fifth held, sixth stalls.
    apply_reset();
    bus.s_bready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.s_awaddr = 12'(4 * i); bus.s_wdata = 32'hBAD00000 | 32'(i); bus.s_wstrb = 4'hF;
      bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
      check("flood_awready", bus.s_awready, 1'b1);
      tick();
      bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
      tick();
    end
    check("flood_level_full", fifo_level, 5'd4);
    check("flood_aw_bp", bus.s_awready, 1'b0);
    check("flood_w_bp", bus.s_wready, 1'b0);
    bus.s_awaddr = 12'h014; bus.s_wdata = 32'hBAD00005;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("flood_stall", stall_count, 16'(k));
    end
    check("flood_still_full", fifo_level, 5'd4);
    bus.s_bready = 1'b1;
    nresp = 0;
    for (int c = 0; c < 30; c++) begin
      logic hs;
      hs = bus.s_awvalid && bus.s_awready;
      if (bus.s_bvalid) begin
        nresp++;
        check("flood_bresp", bus.s_bresp, OKAY);
      end
      tick();
      if (hs) begin
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
      end
      if (c == 0) check("full_push_pop_level", fifo_level, 5'd4);
    end
    check("flood_nresp", nresp, 6);
    check("flood_level_end", fifo_level, 5'd0);
    check("flood_stall_end", stall_count, 16'd6);
    for (int i = 0; i < 6; i++)
      read_chk("flood_rd", 12'(4 * i), 32'hBAD00000 | 32'(i), OKAY);

    // Reset with queued responses and a held AW discards everything.
    bus.s_bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.s_awaddr = 12'(4 * i); bus.s_wdata = 32'h0F0F0000 | 32'(i); bus.s_wstrb = 4'hF;
      bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
      tick();
      bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
      tick();
    end
    bus.s_awaddr = 12'h00C; bus.s_awvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0;
    check("mid_level3", fifo_level, 5'd3);
    check("mid_aw_held", bus.s_awready, 1'b0);
    check("mid_w_free", bus.s_wready, 1'b1);
    reset_n = 1'b1;
    #1;
    check("mid_bvalid", bus.s_bvalid, 1'b0);
    check("mid_level0", fifo_level, 5'd0);
    check("mid_awready", bus.s_awready, 1'b0);
    tick();
    reset_n = 1'b0;
    #1;
    check("mid_rel_awready", bus.s_awready, 1'b1);
    check("mid_rel_stall", stall_count, 16'd0);
    bus.s_bready = 1'b1;
    for (int i = 0; i < 16; i++)
      read_chk("mid_rd_zero", 12'(4 * i), 32'd0, OKAY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axil_flood_responder.md
AXIL_FLOOD_RESPONDER -- requirements
Module: axil_flood_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, setting the write-response FIFO depth in entries (legal 2..16).
REQ-002 The block SHALL have parameter NREGS, default 16, setting the number of 32-bit registers (power of two, legal 2..64).
REQ-003 Port: clk  in  1  rising-edge clock for all state.
REQ-004 Port: reset_n  in  1  reset, asynchronous, active-high.
REQ-005 Ports, AW channel: s_awaddr in 12 (byte address); s_awvalid in 1; s_awready out 1.
REQ-006 Ports, W channel: s_wdata in 32; s_wstrb in 4 (byte enables); s_wvalid in 1; s_wready out 1.
REQ-007 Ports, B channel: s_bresp out 2; s_bvalid out 1; s_bready in 1.
REQ-008 Ports, AR channel: s_araddr in 12; s_arvalid in 1; s_arready out 1.
REQ-009 Ports, R channel: s_rdata out 32; s_rresp out 2; s_rvalid out 1; s_rready in 1.
REQ-010 Port: stall_count  out  16  number of cycles with s_awvalid=1 and s_awready=0, saturating.
REQ-011 Port: fifo_level  out  5  current B-FIFO occupancy.

Function
REQ-012 A handshake SHALL occur on any channel in a cycle where valid=1 and ready=1 at the rising edge.
REQ-013 Register index SHALL be addr[log2(NREGS)+1:2]; any address with a set bit above that field, or addr[1:0]!=0, is out of range.
REQ-014 The AW and W channels SHALL each have an independent 1-entry holding register; s_awready = !aw_held, s_wready = !w_held; AW and W may arrive in any order or in the same cycle.
REQ-015 A commit SHALL occur in any cycle where aw_held=1, w_held=1 and (fifo_level<DEPTH or a B pop occurs in the same cycle).
REQ-016 On commit: if in range, bytes of the indexed register with wstrb[i]=1 are updated; the response OKAY (2'b00), or SLVERR (2'b10) for out of range with no write, is pushed into the B FIFO; both holds clear.
REQ-017 Latency: AW and W handshaked in cycle N with the FIFO not full -> commit in cycle N+1 -> s_bvalid=1 in cycle N+2.
REQ-018 s_bvalid SHALL equal (fifo_level!=0); s_bresp SHALL be the FIFO head; a pop occurs on s_bvalid&&s_bready; responses leave in commit order.
REQ-019 Simultaneous push and pop SHALL leave fifo_level unchanged; a push at full without a pop SHALL never occur; a pop when empty SHALL never occur.
REQ-020 When the FIFO is full and holds are occupied, s_awready/s_wready SHALL stay 0 until a pop frees space (backpressure, no drop, no overwrite).
REQ-021 Reads SHALL have one outstanding transaction: s_arready = !s_rvalid; after an AR handshake in cycle N, s_rvalid=1 with s_rdata/s_rresp valid in cycle N+1, held stable until s_rready=1.
REQ-022 Out-of-range reads SHALL return s_rdata=0, s_rresp=SLVERR; in-range reads return the register value and OKAY.
REQ-023 A read and a commit to the same register in the same cycle SHALL return the pre-write value.
REQ-024 stall_count SHALL increment by 1 per stalled-AW cycle and hold at 16'hFFFF.

Reset
REQ-025 While reset_n=1, all state SHALL clear asynchronously: registers=0, holds empty, FIFO empty, fifo_level=0, s_bvalid=0, s_rvalid=0, s_rdata=0, s_bresp=0, s_rresp=0, stall_count=0.
REQ-026 While reset_n=1, s_awready, s_wready and s_arready SHALL be 0; they SHALL be 1 in the first cycle after deassertion.
REQ-027 Reset asserted mid-transaction SHALL discard pending holds and queued responses with no register write.

Verification
REQ-028 Write 0x4 data 0xCAFE0001 strb 0xF, AW+W in same cycle, s_bready=1 -> s_bvalid two cycles later with OKAY; read 0x4 -> 0xCAFE0001, OKAY.
REQ-029 s_bready=0, issue 6 writes (0xBAD00000|i to 4*i) -> after 4 commits fifo_level=4, 5th AW+W held, 6th AW stalls with stall_count incrementing each cycle; then s_bready=1 -> 6 OKAY responses in order, all data readable.
REQ-030 W handshaked 3 cycles before AW -> exactly one commit, after the AW arrives; strb 0x3 write of 0xFFFFFFFF over 0x12345678 reads back 0x1234FFFF.
REQ-031 Write to 0x100 and read 0x100 -> SLVERR on both, rdata=0, no register changed.
REQ-032 FIFO full with s_bready=1 and a commit in the same cycle -> fifo_level stays 4, no response lost.
REQ-033 Assert reset_n with 3 queued responses and one held AW -> s_bvalid=0, fifo_level=0 immediately; subsequent reads of all registers return 0.
